digitron_display_decoder: RTL and testbench
===========================================

Name: digitron_display_decoder

Overview:
- Decoding end of the multiplexed 6-digit seven-segment clock display bus.
- Samples segment byte and active-low digit-select lines as driven by the clock's display driver.
- Debounces each select phase, decodes segment patterns back to BCD, and rebuilds SecL..HourH and Week.
- Used as a loopback checker on the clock board and as the source for a remote/secondary display.

Parameters:
STABLE_CNT, 4, consecutive identical samples of {Seg_In,SegCS_In} required before a commit (legal range 2..255)
WEEK_DWELL, 16'd1000, cycles SegCS_In must stay at 6'b11_1110 to classify the bus as week mode (must exceed the driver's per-digit period of 201 cycles)

Ports:
CLK  input  1  system clock
RSTn  input  1  reset; synchronous, active-low
Seg_In  input  8  segment byte, active-high, bit6..bit0 = g..a
SegCS_In  input  6  digit select, active-low one-hot
SecL, SecH, MinL, MinH, HourL, HourH  output  4 each  reconstructed BCD time digits
Week  output  4  reconstructed week digit, 0..7
Week_Mode  output  1  level; bus currently shows week
Time_Valid  output  1  level; at least one full 6-digit frame decoded since reset
Frame_Valid  output  1  one-cycle pulse when all 6 time slots have been committed
Err  output  1  one-cycle pulse on an illegal segment pattern or an illegal select
Err_Cnt  output  8  saturating count of Err pulses

Behaviour:
- Reset (RSTn=0 at posedge CLK): every output 0; sample registers, stability counter, dwell counter, seen-mask, pending slot-0 byte and pending flag cleared.
- Input stage: Seg_In/SegCS_In registered once (seg_q, cs_q). All logic below uses seg_q/cs_q.
- Stability: stab_cnt increments (saturating at STABLE_CNT) while {seg_q,cs_q} equals the previous cycle's value; otherwise it resets to 0. A commit fires exactly once per stable phase, on the cycle stab_cnt reaches STABLE_CNT-1.
- Select check at commit: cs_q must contain exactly one 0. Otherwise: Err pulse, no digit update.
- Slot map: 11_1110 slot0, 11_1101 SecH, 11_1011 MinL, 11_0111 MinH, 10_1111 HourL, 01_1111 HourH.
- Time decode: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9. Any other value: Err pulse, target digit unchanged, seen-mask bit not set.
- Slots 1..5: the decoded digit is written to its output on the commit cycle plus 1; the seen-mask bit is set.
- Slot 0 is deferred because it is ambiguous between SecL and Week:
  - On commit, raw seg_q is stored as the pending byte and the pending flag is set.
  - If cs_q leaves 11_1110 before the dwell counter reaches WEEK_DWELL, the pending byte is time-decoded into SecL, mask bit 0 is set, and pending is cleared.
  - If the dwell reaches WEEK_DWELL, the pending byte is week-decoded into Week, pending is cleared, and the mask is not touched.
- Dwell counter: counts while cs_q==11_1110; clears on any other value; 16-bit, saturating.
- Week_Mode: set on the cycle the dwell reaches WEEK_DWELL; cleared on the cycle cs_q leaves 11_1110.
- While Week_Mode=1, any new slot-0 commit (segment change) goes directly to Week.
- Week decode: 0x3F..0x7D -> 0..6; 0x7F -> 7 and 0x07 -> 7. Any other value, including 0x6F (digit 9): Err pulse, Week unchanged.
- Frame: when the seen-mask reaches 6'b11_1111, Frame_Valid pulses for 1 cycle, Time_Valid is set, and the mask clears on the same cycle.
- Simultaneous events:
  - If a slot-5 commit and a pending SecL flush complete the mask on the same cycle, one Frame_Valid pulse is issued.
  - Err and Frame_Valid may assert on the same cycle.
- Err_Cnt increments by 1 per Err pulse and saturates at 255.
- Reset mid-phase discards all partial state; the first commit after reset needs a fresh STABLE_CNT window.

Test Plan:
- Rotate select through all 6 slots, 201 cycles each, with segments for 12:34:56 -> HourH=1, HourL=2, MinH=3, MinL=4, SecH=5, SecL=6; Frame_Valid pulses once; Time_Valid=1.
- Hold SegCS_In=11_1110, Seg_In=0x7F for 1500 cycles -> Week_Mode rises at dwell 1000; Week=7; SecL unchanged; then rotate select -> Week_Mode=0 the cycle after cs_q changes.
- Glitch Seg_In for 2 cycles inside a stable phase (STABLE_CNT=4) -> no commit from the glitch; the correct value commits after 4 stable samples.
- Seg_In=0x00 on slot MinL -> Err one pulse, Err_Cnt=1, MinL keeps its old value, no Frame_Valid for that frame.
- SegCS_In=11_1100 held stable -> Err pulse, no digit changes; 300 Err events -> Err_Cnt saturates at 255.
- Assert RSTn=0 for 1 cycle mid-frame after 3 slots committed -> all outputs 0; the next Frame_Valid requires all 6 slots again.

Source files
------------

// File: rtl/digitron_display_decoder.sv
// rtl/digitron_display_decoder.sv - decodes the multiplexed 6-digit seven-segment bus back to BCD time and week
module digitron_display_decoder #(
    parameter int          STABLE_CNT = 4,
    parameter logic [15:0] WEEK_DWELL = 16'd1000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] Seg_In,
    input  logic [5:0] SegCS_In,
    output logic [3:0] SecL,
    output logic [3:0] SecH,
    output logic [3:0] MinL,
    output logic [3:0] MinH,
    output logic [3:0] HourL,
    output logic [3:0] HourH,
    output logic [3:0] Week,
    output logic       Week_Mode,
    output logic       Time_Valid,
    output logic       Frame_Valid,
    output logic       Err,
    output logic [7:0] Err_Cnt
);

    localparam logic [5:0]  CS_SLOT0    = 6'b11_1110;
    localparam logic [7:0]  STAB_MAX    = 8'(STABLE_CNT);
    localparam logic [7:0]  STAB_COMMIT = 8'(STABLE_CNT - 2);
    localparam logic [15:0] DWELL_HIT   = WEEK_DWELL - 16'd1;

    // Result format: {valid, digit}
    function automatic logic [4:0] timeDecode(input logic [7:0] seg);
        case (seg)
            8'h3F:   return {1'b1, 4'd0};
            8'h06:   return {1'b1, 4'd1};
            8'h5B:   return {1'b1, 4'd2};
            8'h4F:   return {1'b1, 4'd3};
            8'h66:   return {1'b1, 4'd4};
            8'h6D:   return {1'b1, 4'd5};
            8'h7D:   return {1'b1, 4'd6};
            8'h07:   return {1'b1, 4'd7};
            8'h7F:   return {1'b1, 4'd8};
            8'h6F:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    // The driver shows day 7 either as a full "8" or as a plain "7"
    function automatic logic [4:0] weekDecode(input logic [7:0] seg);
        case (seg)
            8'h3F:        return {1'b1, 4'd0};
            8'h06:        return {1'b1, 4'd1};
            8'h5B:        return {1'b1, 4'd2};
            8'h4F:        return {1'b1, 4'd3};
            8'h66:        return {1'b1, 4'd4};
            8'h6D:        return {1'b1, 4'd5};
            8'h7D:        return {1'b1, 4'd6};
            8'h7F, 8'h07: return {1'b1, 4'd7};
            default:      return 5'd0;
        endcase
    endfunction

    logic [7:0]  segQ, segPrev, pendByte, stabCnt;
    logic [5:0]  csQ, csPrev, seenMask, maskSet, maskNext;
    logic [15:0] dwellCnt, dwellNext;
    logic [4:0]  segTime, segWeek, pendTime, pendWeek;
    logic        pendFlag, samePhase, commit, oneSel, inSlot0, leave;
    logic        dwellHit, flushSec, flushWeek, toWeek, errNow;

    assign segTime   = timeDecode(segQ);
    assign segWeek   = weekDecode(segQ);
    assign pendTime  = timeDecode(pendByte);
    assign pendWeek  = weekDecode(pendByte);
    assign samePhase = (segQ == segPrev) && (csQ == csPrev);
    assign commit    = samePhase && (stabCnt == STAB_COMMIT);
    assign oneSel    = ($countones(~csQ) == 1);
    assign inSlot0   = (csQ == CS_SLOT0);
    assign leave     = !inSlot0 && (csPrev == CS_SLOT0);
    assign dwellHit  = inSlot0 && (dwellCnt == DWELL_HIT);
    assign dwellNext = !inSlot0 ? 16'd0 : (dwellCnt == 16'hFFFF) ? dwellCnt : dwellCnt + 16'd1;
    assign flushSec  = leave && pendFlag;
    assign flushWeek = dwellHit && pendFlag;
    assign toWeek    = Week_Mode || dwellHit;

    always_comb begin
        errNow  = 1'b0;
        maskSet = 6'b0;
        if (flushSec) begin
            if (pendTime[4]) maskSet[0] = 1'b1;
            else             errNow     = 1'b1;
        end
        if (flushWeek && !pendWeek[4]) errNow = 1'b1;
        if (commit) begin
            if (!oneSel) begin
                errNow = 1'b1;
            end else if (inSlot0) begin
                if (toWeek && !segWeek[4]) errNow = 1'b1;
            end else if (segTime[4]) begin
                maskSet = maskSet | ~csQ;
            end else begin
                errNow = 1'b1;
            end
        end
        maskNext = seenMask | maskSet;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            segQ        <= 8'd0;
            segPrev     <= 8'd0;
            csQ         <= 6'd0;
            csPrev      <= 6'd0;
            stabCnt     <= 8'd0;
            dwellCnt    <= 16'd0;
            seenMask    <= 6'd0;
            pendByte    <= 8'd0;
            pendFlag    <= 1'b0;
            SecL        <= 4'd0;
            SecH        <= 4'd0;
            MinL        <= 4'd0;
            MinH        <= 4'd0;
            HourL       <= 4'd0;
            HourH       <= 4'd0;
            Week        <= 4'd0;
            Week_Mode   <= 1'b0;
            Time_Valid  <= 1'b0;
            Frame_Valid <= 1'b0;
            Err         <= 1'b0;
            Err_Cnt     <= 8'd0;
        end else begin
            segQ     <= Seg_In;
            csQ      <= SegCS_In;
            segPrev  <= segQ;
            csPrev   <= csQ;
            stabCnt  <= !samePhase ? 8'd0 : (stabCnt == STAB_MAX) ? stabCnt : stabCnt + 8'd1;
            dwellCnt <= dwellNext;

            if (dwellHit)   Week_Mode <= 1'b1;
            else if (leave) Week_Mode <= 1'b0;

            // A slot-0 byte is only resolved once we know how long the select dwelt there
            if (flushSec) begin
                pendFlag <= 1'b0;
                if (pendTime[4]) SecL <= pendTime[3:0];
            end
            if (flushWeek) begin
                pendFlag <= 1'b0;
                if (pendWeek[4]) Week <= pendWeek[3:0];
            end

            if (commit && oneSel) begin
                if (inSlot0) begin
                    if (toWeek) begin
                        if (segWeek[4]) Week <= segWeek[3:0];
                    end else begin
                        pendByte <= segQ;
                        pendFlag <= 1'b1;
                    end
                end else if (segTime[4]) begin
                    case (csQ)
                        6'b11_1101: SecH  <= segTime[3:0];
                        6'b11_1011: MinL  <= segTime[3:0];
                        6'b11_0111: MinH  <= segTime[3:0];
                        6'b10_1111: HourL <= segTime[3:0];
                        6'b01_1111: HourH <= segTime[3:0];
                        default:    ;
                    endcase
                end
            end

            Err <= errNow;
            if (errNow && Err_Cnt != 8'hFF) Err_Cnt <= Err_Cnt + 8'd1;

            if (maskNext == 6'b11_1111) begin
                Frame_Valid <= 1'b1;
                Time_Valid  <= 1'b1;
                seenMask    <= 6'd0;
            end else begin
                Frame_Valid <= 1'b0;
                seenMask    <= maskNext;
            end
        end
    end

endmodule

// File: tb/tb_digitron_display_decoder.sv
// tb/tb_digitron_display_decoder.sv - randomized display-bus stimulus against a per-phase reference model
module tb_digitron_display_decoder;

    localparam int WEEK_DWELL = 1000;

    logic       CLK;
    logic       RSTn;
    logic [7:0] Seg_In;
    logic [5:0] SegCS_In;
    logic [3:0] SecL, SecH, MinL, MinH, HourL, HourH, Week;
    logic       Week_Mode, Time_Valid, Frame_Valid, Err;
    logic [7:0] Err_Cnt;

    digitron_display_decoder dut (
        .CLK(CLK), .RSTn(RSTn), .Seg_In(Seg_In), .SegCS_In(SegCS_In),
        .SecL(SecL), .SecH(SecH), .MinL(MinL), .MinH(MinH), .HourL(HourL), .HourH(HourH),
        .Week(Week), .Week_Mode(Week_Mode), .Time_Valid(Time_Valid),
        .Frame_Valid(Frame_Valid), .Err(Err), .Err_Cnt(Err_Cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] segTab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [5:0] slotCs [6]  = '{6'b11_1110, 6'b11_1101, 6'b11_1011, 6'b11_0111, 6'b10_1111, 6'b01_1111};

    int total = 0;
    int bad = 0;
    int frameSeen = 0;
    int errSeen = 0;

    always @(negedge CLK) begin
        if (Frame_Valid === 1'b1) frameSeen++;
        if (Err === 1'b1) errSeen++;
    end

    int mDig [6];
    bit mSeen [6];
    int mWeek, mErrCnt, mErrTotal, mFrameTotal, mPend, mDwell;
    bit mTV, mWM;

    function automatic int timeVal(input logic [7:0] b);
        for (int d = 0; d < 10; d++) if (segTab[d] == b) return d;
        return -1;
    endfunction

    function automatic int weekVal(input logic [7:0] b);
        if (b == 8'h7F || b == 8'h07) return 7;
        for (int d = 0; d < 7; d++) if (segTab[d] == b) return d;
        return -1;
    endfunction

    function automatic void mClear();
        for (int i = 0; i < 6; i++) begin mDig[i] = 0; mSeen[i] = 0; end
        mWeek = 0; mErrCnt = 0; mTV = 0; mWM = 0; mPend = -1; mDwell = 0;
    endfunction

    function automatic void mErr();
        mErrCnt++;
        mErrTotal++;
    endfunction

    function automatic void mMark(input int k);
        bit all;
        mSeen[k] = 1;
        all = 1;
        for (int i = 0; i < 6; i++) all &= mSeen[i];
        if (all) begin
            mFrameTotal++;
            mTV = 1;
            for (int i = 0; i < 6; i++) mSeen[i] = 0;
        end
    endfunction

    // One bus phase: leaving slot 0 resolves the held byte as seconds, then this phase's value lands
    function automatic void modelPhase(input logic [5:0] cs, input logic [7:0] seg, input int cycles);
        int zeros, slot, v;
        zeros = 0; slot = -1;
        for (int i = 0; i < 6; i++) if (!cs[i]) begin zeros++; slot = i; end
        if (cs != slotCs[0]) begin
            if (mPend >= 0) begin
                v = timeVal(mPend[7:0]);
                if (v < 0) mErr(); else begin mDig[0] = v; mMark(0); end
                mPend = -1;
            end
            mWM = 0;
            mDwell = 0;
        end
        if (zeros != 1) begin
            mErr();
        end else if (slot == 0) begin
            if (mWM) begin
                v = weekVal(seg);
                if (v < 0) mErr(); else mWeek = v;
            end else begin
                mPend = int'(seg);
            end
            mDwell += cycles;
            if (!mWM && mDwell > WEEK_DWELL) begin
                mWM = 1;
                if (mPend >= 0) begin
                    v = weekVal(mPend[7:0]);
                    if (v < 0) mErr(); else mWeek = v;
                    mPend = -1;
                end
            end
        end else begin
            v = timeVal(seg);
            if (v < 0) mErr(); else begin mDig[slot] = v; mMark(slot); end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic go(input logic [5:0] cs, input logic [7:0] seg, input int cycles);
        modelPhase(cs, seg, cycles);
        SegCS_In = cs;
        Seg_In = seg;
        waitc(cycles);
    endtask

    task automatic sendSegs(input logic [7:0] s0, s1, s2, s3, s4, s5);
        go(slotCs[0], s0, 201); go(slotCs[1], s1, 201); go(slotCs[2], s2, 201);
        go(slotCs[3], s3, 201); go(slotCs[4], s4, 201); go(slotCs[5], s5, 201);
    endtask

    task automatic randFrame();
        sendSegs(segTab[$urandom_range(0, 9)], segTab[$urandom_range(0, 9)], segTab[$urandom_range(0, 9)],
                 segTab[$urandom_range(0, 9)], segTab[$urandom_range(0, 9)], segTab[$urandom_range(0, 9)]);
    endtask

    task automatic checkAll(input string tag);
        chk({tag, "_secl"}, SecL, mDig[0]);
        chk({tag, "_sech"}, SecH, mDig[1]);
        chk({tag, "_minl"}, MinL, mDig[2]);
        chk({tag, "_minh"}, MinH, mDig[3]);
        chk({tag, "_hourl"}, HourL, mDig[4]);
        chk({tag, "_hourh"}, HourH, mDig[5]);
        chk({tag, "_week"}, Week, mWeek);
        chk({tag, "_week_mode"}, Week_Mode, mWM);
        chk({tag, "_time_valid"}, Time_Valid, mTV);
        chk({tag, "_err_cnt"}, Err_Cnt, (mErrCnt > 255) ? 255 : mErrCnt);
        chk({tag, "_frames"}, frameSeen, mFrameTotal);
        chk({tag, "_err_pulses"}, errSeen, mErrTotal);
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_digits"}, {SecL, SecH, MinL, MinH, HourL, HourH, Week}, 0);
        chk({tag, "_flags"}, {Week_Mode, Time_Valid, Frame_Valid, Err}, 0);
        chk({tag, "_err_cnt"}, Err_Cnt, 0);
    endtask

    initial begin
        int d, g, old, idx;
        logic [7:0] w1, w2;
        mErrTotal = 0;
        mFrameTotal = 0;
        mClear();

        RSTn = 1'b0;
        SegCS_In = slotCs[5];
        Seg_In = 8'h3F;
        waitc(3);
        checkZero("reset");
        RSTn = 1'b1;
        go(slotCs[5], 8'h3F, 20);

        sendSegs(segTab[6], segTab[5], segTab[4], segTab[3], segTab[2], segTab[1]);
        checkAll("frame_123456");
        chk("frame_123456_hhmmss", {HourH, HourL, MinH, MinL, SecH, SecL}, 24'h123456);

        for (int i = 0; i < 4; i++) begin
            randFrame();
            checkAll($sformatf("rand_frame%0d", i));
        end

        old = mDig[3];
        d = (old + 1 + $urandom_range(0, 8)) % 10;
        modelPhase(slotCs[3], segTab[d], 0);
        SegCS_In = slotCs[3];
        Seg_In = segTab[d];
        waitc(4);
        chk("stab_early", MinH, old);
        waitc(2);
        chk("stab_commit", MinH, d);
        waitc(40);
        g = (d + 1 + $urandom_range(0, 8)) % 10;
        Seg_In = segTab[g];
        waitc(2);
        Seg_In = segTab[d];
        modelPhase(slotCs[3], segTab[d], 0);
        waitc(6);
        chk("glitch_no_commit", MinH, d);
        waitc(40);
        checkAll("glitch");

        sendSegs(segTab[$urandom_range(0, 9)], segTab[$urandom_range(0, 9)], 8'h00,
                 segTab[$urandom_range(0, 9)], segTab[$urandom_range(0, 9)], segTab[$urandom_range(0, 9)]);
        checkAll("minl_bad");

        modelPhase(slotCs[0], 8'h7F, 1500);
        SegCS_In = slotCs[0];
        Seg_In = 8'h7F;
        waitc(1000);
        chk("week_mode_before_dwell", Week_Mode, 0);
        waitc(1);
        chk("week_mode_at_dwell", Week_Mode, 1);
        chk("week_value", Week, 7);
        chk("week_secl_kept", SecL, mDig[0]);
        waitc(499);
        d = $urandom_range(0, 9);
        modelPhase(slotCs[1], segTab[d], 201);
        SegCS_In = slotCs[1];
        Seg_In = segTab[d];
        waitc(1);
        chk("week_mode_hold", Week_Mode, 1);
        waitc(1);
        chk("week_mode_drop", Week_Mode, 0);
        waitc(199);
        for (int s = 2; s < 6; s++) go(slotCs[s], segTab[$urandom_range(0, 9)], 201);
        checkAll("week_fixed");

        idx = $urandom_range(0, 7);
        w1 = (idx < 7) ? segTab[idx] : ($urandom_range(0, 1) ? 8'h7F : 8'h07);
        do begin
            idx = $urandom_range(0, 7);
            w2 = (idx < 7) ? segTab[idx] : ($urandom_range(0, 1) ? 8'h7F : 8'h07);
        end while (w2 == w1);
        go(slotCs[0], w1, 1100);
        go(slotCs[0], w2, 400);
        go(slotCs[0], 8'h6F, 300);
        for (int s = 1; s < 6; s++) go(slotCs[s], segTab[$urandom_range(0, 9)], 201);
        checkAll("week_rand");

        go(6'b11_1100, 8'($urandom), 8);
        checkAll("bad_select");
        for (int i = 0; i < 300; i++) go((i % 2 == 0) ? 6'b11_1000 : 6'b11_1100, 8'($urandom), 8);
        checkAll("err_saturate");

        randFrame();
        checkAll("recover");

        d = $urandom_range(0, 9);
        go(slotCs[0], segTab[$urandom_range(0, 9)], 201);
        go(slotCs[1], segTab[$urandom_range(0, 9)], 201);
        go(slotCs[2], segTab[d], 201);
        RSTn = 1'b0;
        waitc(1);
        checkZero("reset_mid");
        RSTn = 1'b1;
        mClear();
        go(slotCs[2], segTab[d], 201);
        for (int s = 3; s < 6; s++) go(slotCs[s], segTab[$urandom_range(0, 9)], 201);
        checkAll("after_reset_partial");
        randFrame();
        checkAll("after_reset_full");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
